// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue unit: widths, FSM state encoding and
// FLAGS bit positions.
package alu_pkg;
  localparam int DATA_W    = 8;
  localparam int OP_W      = 3;
  localparam int REG_IDX_W = 3;
  localparam int NUM_REGS  = 8;
  localparam int CNT_W     = 4;
  localparam int FLAGS_W   = 4;

  // FLAGS is packed {C,V,N,Z} with carry in the MSB
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/regfile.sv
// 8x8 register file: one synchronous write port, three combinational reads
// (two instruction operands plus a debug/display port).
module regfile
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [REG_IDX_W-1:0] ra_addr,
  output logic [DATA_W-1:0]    ra_data,
  input  logic [REG_IDX_W-1:0] rb_addr,
  output logic [DATA_W-1:0]    rb_data,
  input  logic [REG_IDX_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]    dbg_data
);
  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads show the stored value, so a same-cycle write appears only after the edge
  assign ra_data  = regs[ra_addr];
  assign rb_data  = regs[rb_addr];
  assign dbg_data = regs[dbg_addr];
endmodule

// File: rtl/alu_issue_unit.sv
// Single-issue front end for an external combinational ALU: latches operands,
// waits EXEC_CYCLES for the ALU to settle, then writes the result back.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int EXEC_CYCLES = 1
) (
  input  logic                 CLK,
  input  logic                 RST_L,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [OP_W-1:0]      IN_OP,
  input  logic [REG_IDX_W-1:0] IN_RD,
  input  logic [REG_IDX_W-1:0] IN_RA,
  input  logic [REG_IDX_W-1:0] IN_RB,
  input  logic                 LD_EN,
  input  logic [REG_IDX_W-1:0] LD_ADDR,
  input  logic [DATA_W-1:0]    LD_DATA,
  output logic [DATA_W-1:0]    ALU_A,
  output logic [DATA_W-1:0]    ALU_B,
  output logic [OP_W-1:0]      ALU_OP,
  input  logic [DATA_W-1:0]    ALU_Y,
  input  logic                 ALU_C,
  input  logic                 ALU_V,
  input  logic                 ALU_N,
  input  logic                 ALU_Z,
  output logic                 WB_VALID,
  output logic [DATA_W-1:0]    WB_DATA,
  output logic [FLAGS_W-1:0]   FLAGS,
  input  logic [REG_IDX_W-1:0] DBG_RADDR,
  output logic [DATA_W-1:0]    DBG_RDATA
);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(EXEC_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [REG_IDX_W-1:0] rd_q;
  logic                 accept, capture, rf_we;
  logic [REG_IDX_W-1:0] rf_waddr;
  logic [DATA_W-1:0]    rf_wdata, rf_ra_data, rf_rb_data;
  logic [FLAGS_W-1:0]   alu_flags;

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_C] = ALU_C;
    alu_flags[FLAG_V] = ALU_V;
    alu_flags[FLAG_N] = ALU_N;
    alu_flags[FLAG_Z] = ALU_Z;
  end

  regfile u_regfile (
    .clk      (CLK),
    .rst_n    (RST_L),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .ra_addr  (IN_RA),
    .ra_data  (rf_ra_data),
    .rb_addr  (IN_RB),
    .rb_data  (rf_rb_data),
    .dbg_addr (DBG_RADDR),
    .dbg_data (DBG_RDATA)
  );

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Preload and write-back share the single write port; they live in different states
  always_comb begin
    state_d  = state_q;
    IN_READY = 1'b0;
    WB_VALID = 1'b0;
    accept   = 1'b0;
    capture  = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = LD_ADDR;
    rf_wdata = LD_DATA;
    case (state_q)
      ST_IDLE: begin
        IN_READY = ~LD_EN;
        if (LD_EN) begin
          rf_we = 1'b1;
        end else if (IN_VALID) begin
          accept  = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          capture  = 1'b1;
          rf_we    = 1'b1;
          rf_waddr = rd_q;
          rf_wdata = ALU_Y;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        WB_VALID = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      ALU_A   <= '0;
      ALU_B   <= '0;
      ALU_OP  <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      WB_DATA <= '0;
      FLAGS   <= '0;
    end else begin
      if (accept) begin
        ALU_A  <= rf_ra_data;
        ALU_B  <= rf_rb_data;
        ALU_OP <= IN_OP;
        rd_q   <= IN_RD;
        cnt_q  <= CNT_INIT;
      end else if (state_q == ST_EXEC && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (capture) begin
        WB_DATA <= ALU_Y;
        FLAGS   <= alu_flags;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: two instances (EXEC_CYCLES=1 and 3) driven by an adder ALU
// stand-in and checked against a register-array reference model.
module tb_alu_issue_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid [2];
  logic       in_ready [2];
  logic [2:0] in_op [2];
  logic [2:0] in_rd [2];
  logic [2:0] in_ra [2];
  logic [2:0] in_rb [2];
  logic       ld_en [2];
  logic [2:0] ld_addr [2];
  logic [7:0] ld_data [2];
  logic [7:0] alu_a [2];
  logic [7:0] alu_b [2];
  logic [2:0] alu_op [2];
  logic [7:0] alu_y [2];
  logic       alu_c [2];
  logic       alu_v [2];
  logic       alu_n [2];
  logic       alu_z [2];
  logic       wb_valid [2];
  logic [7:0] wb_data [2];
  logic [3:0] flags [2];
  logic [2:0] dbg_raddr [2];
  logic [7:0] dbg_rdata [2];
  logic       force_en [2];
  logic [3:0] force_flags [2];

  logic [7:0] mregs [2][8];
  int n_cmp = 0;
  int n_fail = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [8:0] sum;
    assign sum      = {1'b0, alu_a[g]} + {1'b0, alu_b[g]};
    assign alu_y[g] = sum[7:0];
    assign alu_c[g] = force_en[g] ? force_flags[g][3] : sum[8];
    assign alu_v[g] = force_en[g] ? force_flags[g][2]
                    : ((alu_a[g][7] == alu_b[g][7]) && (sum[7] != alu_a[g][7]));
    assign alu_n[g] = force_en[g] ? force_flags[g][1] : sum[7];
    assign alu_z[g] = force_en[g] ? force_flags[g][0] : (sum[7:0] == 8'h00);

    alu_issue_unit #(.EXEC_CYCLES(g == 0 ? 1 : 3)) dut (
      .CLK(clk), .RST_L(rst_n),
      .IN_VALID(in_valid[g]), .IN_READY(in_ready[g]), .IN_OP(in_op[g]),
      .IN_RD(in_rd[g]), .IN_RA(in_ra[g]), .IN_RB(in_rb[g]),
      .LD_EN(ld_en[g]), .LD_ADDR(ld_addr[g]), .LD_DATA(ld_data[g]),
      .ALU_A(alu_a[g]), .ALU_B(alu_b[g]), .ALU_OP(alu_op[g]),
      .ALU_Y(alu_y[g]), .ALU_C(alu_c[g]), .ALU_V(alu_v[g]), .ALU_N(alu_n[g]), .ALU_Z(alu_z[g]),
      .WB_VALID(wb_valid[g]), .WB_DATA(wb_data[g]), .FLAGS(flags[g]),
      .DBG_RADDR(dbg_raddr[g]), .DBG_RDATA(dbg_rdata[g])
    );
  end

  function automatic int ecyc(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Flags from signed/unsigned integer arithmetic on the operands
  function automatic logic [3:0] ref_flags(input logic [7:0] a, input logic [7:0] b);
    int s, sa, sb, ss, y;
    logic c, v, n, z;
    s  = int'(a) + int'(b);
    y  = s % 256;
    sa = (a >= 128) ? int'(a) - 256 : int'(a);
    sb = (b >= 128) ? int'(b) - 256 : int'(b);
    ss = sa + sb;
    c  = (s > 255);
    v  = (ss > 127) || (ss < -128);
    n  = (y >= 128);
    z  = (y == 0);
    return {c, v, n, z};
  endfunction

  task automatic do_load(input int d, input logic [2:0] addr, input logic [7:0] data);
    ld_en[d] = 1'b1; ld_addr[d] = addr; ld_data[d] = data;
    @(negedge clk);
    ld_en[d] = 1'b0;
    mregs[d][addr] = data;
  endtask

  // Offers one instruction starting now (between negedge and posedge) and watches it.
  // first_wb is the edge index after the accept edge at which WB_VALID is sampled high.
  task automatic run_issue(input int d, input logic [2:0] op, input logic [2:0] rd,
                           input logic [2:0] ra, input logic [2:0] rb, input bit hold,
                           output int waits, output int first_wb, output int pulses,
                           output int busy_ready, output bit unstable,
                           output logic [7:0] a0, output logic [7:0] b0, output logic [2:0] op0);
    int e;
    e = ecyc(d);
    first_wb = -1; pulses = 0; busy_ready = 0; unstable = 1'b0;
    a0 = 'x; b0 = 'x; op0 = 'x;
    in_valid[d] = 1'b1; in_op[d] = op; in_rd[d] = rd; in_ra[d] = ra; in_rb[d] = rb;
    #1;
    waits = 0;
    while (in_ready[d] !== 1'b1 && waits < 20) begin
      @(negedge clk); #1; waits++;
    end
    if (waits >= 20) begin
      in_valid[d] = 1'b0;
      return;
    end
    @(negedge clk);
    a0 = alu_a[d]; b0 = alu_b[d]; op0 = alu_op[d];
    if (!hold) in_valid[d] = 1'b0;
    else begin
      ld_en[d] = 1'b1; ld_addr[d] = ra; ld_data[d] = 8'hEE;
    end
    for (int n = 1; n <= 24; n++) begin
      if (hold && n == e + 2) begin in_valid[d] = 1'b0; ld_en[d] = 1'b0; end
      #1;
      if (hold && n <= e + 1 && in_ready[d] === 1'b1) busy_ready++;
      if (wb_valid[d] === 1'b1) begin
        pulses++;
        if (first_wb < 0) first_wb = n;
      end
      if (n <= e + 1 && (alu_a[d] !== a0 || alu_b[d] !== b0 || alu_op[d] !== op0)) unstable = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 0; in_op[d] = 0; in_rd[d] = 0; in_ra[d] = 0; in_rb[d] = 0;
      ld_en[d] = 0; ld_addr[d] = 0; ld_data[d] = 0; dbg_raddr[d] = 0;
      force_en[d] = 0; force_flags[d] = 0;
      for (int r = 0; r < 8; r++) mregs[d][r] = 8'h00;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (in_ready[d] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready[%0d] got=%b want=1", d, in_ready[d]); end
      n_cmp++; if (wb_valid[d] !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid[%0d] got=%b want=0", d, wb_valid[d]); end
      n_cmp++; if ({alu_a[d], alu_b[d], alu_op[d]} !== 19'd0) begin n_fail++; $display("FAIL reset_alu_regs[%0d] got=%h/%h/%h want=0", d, alu_a[d], alu_b[d], alu_op[d]); end
      n_cmp++; if (wb_data[d] !== 8'h00) begin n_fail++; $display("FAIL reset_wb_data[%0d] got=%h want=00", d, wb_data[d]); end
      n_cmp++; if (flags[d] !== 4'h0) begin n_fail++; $display("FAIL reset_flags[%0d] got=%b want=0000", d, flags[d]); end
      for (int r = 0; r < 8; r++) begin
        dbg_raddr[d] = 3'(r); #1;
        n_cmp++; if (dbg_rdata[d] !== 8'h00) begin n_fail++; $display("FAIL reset_r%0d[%0d] got=%h want=00", r, d, dbg_rdata[d]); end
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (in_ready[d] !== 1'b1) begin n_fail++; $display("FAIL release_in_ready[%0d] got=%b want=1", d, in_ready[d]); end
    end
  endtask

  task automatic test_basic();
    int waits, fw, pulses, busy; bit unst; logic [7:0] a0, b0; logic [2:0] op0;
    ld_en[0] = 1; ld_addr[0] = 1; ld_data[0] = 8'h0F; dbg_raddr[0] = 1; #1;
    n_cmp++; if (dbg_rdata[0] !== 8'h00) begin n_fail++; $display("FAIL dbg_before_edge got=%h want=00", dbg_rdata[0]); end
    @(negedge clk); ld_en[0] = 0; mregs[0][1] = 8'h0F; #1;
    n_cmp++; if (dbg_rdata[0] !== 8'h0F) begin n_fail++; $display("FAIL dbg_after_edge got=%h want=0f", dbg_rdata[0]); end
    do_load(0, 3'd2, 8'h01);
    run_issue(0, 3'd0, 3'd3, 3'd1, 3'd2, 1'b0, waits, fw, pulses, busy, unst, a0, b0, op0);
    n_cmp++; if (waits != 0) begin n_fail++; $display("FAIL basic_accept_wait got=%0d want=0", waits); end
    n_cmp++; if ({a0, b0, op0} !== {8'h0F, 8'h01, 3'd0}) begin n_fail++; $display("FAIL basic_operands got=%h/%h/%h want=0f/01/0", a0, b0, op0); end
    n_cmp++; if (fw != 2 || pulses != 1) begin n_fail++; $display("FAIL basic_wb_timing got=edge%0d x%0d want=edge2 x1", fw, pulses); end
    n_cmp++; if (wb_data[0] !== 8'h10) begin n_fail++; $display("FAIL basic_wb_data got=%h want=10", wb_data[0]); end
    n_cmp++; if (flags[0] !== 4'b0000) begin n_fail++; $display("FAIL basic_flags got=%b want=0000", flags[0]); end
    n_cmp++; if (unst) begin n_fail++; $display("FAIL basic_operand_stable got=changed want=stable"); end
    mregs[0][3] = 8'h10;
    dbg_raddr[0] = 3; #1;
    n_cmp++; if (dbg_rdata[0] !== 8'h10) begin n_fail++; $display("FAIL basic_dbg_r3 got=%h want=10", dbg_rdata[0]); end
  endtask

  task automatic test_chain();
    int waits, fw, pulses, busy; bit unst; logic [7:0] a0, b0; logic [2:0] op0;
    force_en[0] = 1; force_flags[0] = 4'b1000;
    run_issue(0, 3'd0, 3'd3, 3'd3, 3'd3, 1'b0, waits, fw, pulses, busy, unst, a0, b0, op0);
    force_en[0] = 0;
    n_cmp++; if (a0 !== 8'h10 || b0 !== 8'h10) begin n_fail++; $display("FAIL chain_operands got=%h/%h want=10/10", a0, b0); end
    n_cmp++; if (wb_data[0] !== 8'h20) begin n_fail++; $display("FAIL chain_wb_data got=%h want=20", wb_data[0]); end
    n_cmp++; if (flags[0] !== 4'b1000) begin n_fail++; $display("FAIL chain_flags got=%b want=1000", flags[0]); end
    mregs[0][3] = 8'h20;
    dbg_raddr[0] = 3; #1;
    n_cmp++; if (dbg_rdata[0] !== 8'h20) begin n_fail++; $display("FAIL chain_dbg_r3 got=%h want=20", dbg_rdata[0]); end
  endtask

  task automatic test_load_priority();
    int waits, fw, pulses, busy; bit unst; logic [7:0] a0, b0; logic [2:0] op0;
    ld_en[0] = 1; ld_addr[0] = 4; ld_data[0] = 8'h5A;
    in_valid[0] = 1; in_op[0] = 0; in_rd[0] = 6; in_ra[0] = 4; in_rb[0] = 4; #1;
    n_cmp++; if (in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL ldpri_ready_during_load got=%b want=0", in_ready[0]); end
    @(negedge clk); ld_en[0] = 0; mregs[0][4] = 8'h5A;
    run_issue(0, 3'd0, 3'd6, 3'd4, 3'd4, 1'b0, waits, fw, pulses, busy, unst, a0, b0, op0);
    n_cmp++; if (waits != 0) begin n_fail++; $display("FAIL ldpri_accept_next got=wait%0d want=wait0", waits); end
    n_cmp++; if (wb_data[0] !== 8'hB4 || fw != 2) begin n_fail++; $display("FAIL ldpri_wb got=%h@%0d want=b4@2", wb_data[0], fw); end
    n_cmp++; if (flags[0] !== ref_flags(8'h5A, 8'h5A)) begin n_fail++; $display("FAIL ldpri_flags got=%b want=%b", flags[0], ref_flags(8'h5A, 8'h5A)); end
    mregs[0][6] = 8'hB4;
  endtask

  task automatic test_exec3();
    int waits, fw, pulses, busy; bit unst; logic [7:0] a0, b0; logic [2:0] op0;
    do_load(1, 3'd1, 8'h30);
    do_load(1, 3'd2, 8'h07);
    run_issue(1, 3'd2, 3'd2, 3'd1, 3'd2, 1'b1, waits, fw, pulses, busy, unst, a0, b0, op0);
    n_cmp++; if (fw != 4 || pulses != 1) begin n_fail++; $display("FAIL exec3_wb_timing got=edge%0d x%0d want=edge4 x1", fw, pulses); end
    n_cmp++; if (busy != 0) begin n_fail++; $display("FAIL exec3_ready_while_busy got=%0d want=0", busy); end
    n_cmp++; if (op0 !== 3'd2 || unst) begin n_fail++; $display("FAIL exec3_alu_op got=%0d unstable=%b want=2 stable", op0, unst); end
    n_cmp++; if (wb_data[1] !== 8'h37) begin n_fail++; $display("FAIL exec3_wb_data got=%h want=37", wb_data[1]); end
    mregs[1][2] = 8'h37;
    dbg_raddr[1] = 1; #1;
    n_cmp++; if (dbg_rdata[1] !== 8'h30) begin n_fail++; $display("FAIL exec3_load_ignored got=%h want=30", dbg_rdata[1]); end
  endtask

  task automatic test_back_to_back();
    int accepts = 0, pulses = 0, last_acc = -100, bad_gap = 0, bad_lat = 0;
    logic [7:0] q [$];
    logic [7:0] y, want;
    do_load(0, 3'd1, 8'($urandom));
    do_load(0, 3'd2, 8'($urandom));
    in_valid[0] = 1; in_op[0] = 0; in_rd[0] = 1; in_ra[0] = 1; in_rb[0] = 2;
    for (int n = 0; n < 36; n++) begin
      if (n == 30) in_valid[0] = 0;
      #1;
      if (wb_valid[0] === 1'b1) begin
        pulses++;
        if (n - last_acc != 2) bad_lat++;
        want = (q.size() > 0) ? q.pop_front() : 8'hxx;
        n_cmp++; if (wb_data[0] !== want) begin n_fail++; $display("FAIL b2b_wb_data got=%h want=%h", wb_data[0], want); end
      end
      if (in_valid[0] && in_ready[0] === 1'b1) begin
        if (accepts > 0 && n - last_acc != 3) bad_gap++;
        accepts++; last_acc = n;
        y = mregs[0][1] + mregs[0][2];
        mregs[0][1] = y;
        q.push_back(y);
      end
      @(negedge clk);
    end
    n_cmp++; if (accepts != 10 || bad_gap != 0) begin n_fail++; $display("FAIL b2b_accept_rate got=%0d accepts %0d bad gaps want=10 accepts 0 bad", accepts, bad_gap); end
    n_cmp++; if (pulses != accepts || bad_lat != 0) begin n_fail++; $display("FAIL b2b_pulses got=%0d pulses %0d late want=%0d 0 late", pulses, bad_lat, accepts); end
  endtask

  task automatic test_random();
    int waits, fw, pulses, busy; bit unst; logic [7:0] a0, b0; logic [2:0] op0;
    logic [2:0] rd, ra, rb; logic [7:0] y; logic [3:0] fl;
    for (int d = 0; d < 2; d++) begin
      for (int it = 0; it < 10; it++) begin
        if ($urandom_range(0, 2) == 0) begin
          do_load(d, 3'($urandom), 8'($urandom));
        end else begin
          rd = 3'($urandom); ra = 3'($urandom); rb = 3'($urandom);
          y  = mregs[d][ra] + mregs[d][rb];
          fl = ref_flags(mregs[d][ra], mregs[d][rb]);
          run_issue(d, 3'($urandom), rd, ra, rb, 1'b0, waits, fw, pulses, busy, unst, a0, b0, op0);
          n_cmp++; if (waits != 0 || fw != ecyc(d) + 1 || pulses != 1) begin n_fail++; $display("FAIL rand_timing[%0d] got=wait%0d edge%0d x%0d want=wait0 edge%0d x1", d, waits, fw, pulses, ecyc(d) + 1); end
          n_cmp++; if (wb_data[d] !== y || flags[d] !== fl) begin n_fail++; $display("FAIL rand_result[%0d] got=%h/%b want=%h/%b", d, wb_data[d], flags[d], y, fl); end
          mregs[d][rd] = y;
          dbg_raddr[d] = rd; #1;
          n_cmp++; if (dbg_rdata[d] !== y) begin n_fail++; $display("FAIL rand_dbg[%0d] r%0d got=%h want=%h", d, rd, dbg_rdata[d], y); end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    do_load(1, 3'd5, 8'hAA);
    do_load(1, 3'd1, 8'h01);
    in_valid[1] = 1; in_op[1] = 0; in_rd[1] = 5; in_ra[1] = 1; in_rb[1] = 1; #1;
    n_cmp++; if (in_ready[1] !== 1'b1) begin n_fail++; $display("FAIL rstmid_accept got=%b want=1", in_ready[1]); end
    @(negedge clk); in_valid[1] = 0;
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    n_cmp++; if (in_ready[1] !== 1'b1 || alu_a[1] !== 8'h00) begin n_fail++; $display("FAIL rstmid_async got=rdy%b a=%h want=rdy1 a=00", in_ready[1], alu_a[1]); end
    @(negedge clk); rst_n = 1'b1;
    for (int d = 0; d < 2; d++) for (int r = 0; r < 8; r++) mregs[d][r] = 8'h00;
    for (int n = 0; n < 8; n++) begin
      #1;
      if (wb_valid[0] === 1'b1 || wb_valid[1] === 1'b1) pulses++;
      @(negedge clk);
    end
    n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL rstmid_no_wb got=%0d pulses want=0", pulses); end
    dbg_raddr[1] = 5; #1;
    n_cmp++; if (dbg_rdata[1] !== 8'h00) begin n_fail++; $display("FAIL rstmid_r5 got=%h want=00", dbg_rdata[1]); end
    n_cmp++; if (flags[1] !== 4'h0 || wb_data[1] !== 8'h00) begin n_fail++; $display("FAIL rstmid_flags got=%b/%h want=0000/00", flags[1], wb_data[1]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_chain();
    test_load_priority();
    test_exec3();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/alu_issue_unit.md
ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 SHALL have parameter EXEC_CYCLES, default 1, meaning ALU settle cycles allowed before result capture (legal 1..15).
REQ-002 SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port RST_L  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port IN_VALID  input  1  instruction offered.
REQ-005 SHALL have port IN_READY  output  1  instruction accepted when IN_VALID & IN_READY at a rising edge.
REQ-006 SHALL have ports IN_OP  input  3  ALU opcode; IN_RD, IN_RA, IN_RB  input  3 each  destination and source register indices.
REQ-007 SHALL have ports LD_EN  input  1, LD_ADDR  input  3, LD_DATA  input  8  register preload.
REQ-008 SHALL have ports ALU_A, ALU_B  output  8, ALU_OP  output  3  registered operands/opcode driving the ALU.
REQ-009 SHALL have ports ALU_Y  input  8, ALU_C, ALU_V, ALU_N, ALU_Z  input  1 each  ALU result and flags.
REQ-010 SHALL have ports WB_VALID  output  1, WB_DATA  output  8, FLAGS  output  4 ({C,V,N,Z}, C at bit 3).
REQ-011 SHALL have ports DBG_RADDR  input  3, DBG_RDATA  output  8  combinational register-file read for display.

Function
REQ-012 SHALL hold eight 8-bit registers r0..r7, all writable, no hardwired zero.
REQ-013 SHALL implement states IDLE, EXEC, DONE.
REQ-014 IDLE: IN_READY = ~LD_EN; on LD_EN write LD_DATA to r[LD_ADDR] and stay IDLE (load wins over issue).
REQ-015 IDLE accept: ALU_A <= r[IN_RA], ALU_B <= r[IN_RB], ALU_OP <= IN_OP, latch IN_RD, load 4-bit counter with EXEC_CYCLES-1, go EXEC.
REQ-016 EXEC: IN_READY=0, LD_EN ignored; counter decrements each cycle; at edge with counter==0 write ALU_Y to r[rd], WB_DATA <= ALU_Y, FLAGS <= {ALU_C,ALU_V,ALU_N,ALU_Z}, go DONE.
REQ-017 DONE: WB_VALID=1 for exactly this one cycle, IN_READY=0, LD_EN ignored; next edge go IDLE.
REQ-018 Latency accept-edge to WB_VALID high SHALL be EXEC_CYCLES+1 cycles; back-to-back issue rate one per EXEC_CYCLES+2 cycles.
REQ-019 ALU_A/ALU_B/ALU_OP SHALL stay stable from accept until return to IDLE.
REQ-020 Source reads SHALL see prior write-backs (RA or RB equal previous RD returns new value); RA==RB==RD legal.
REQ-021 WB_DATA and FLAGS SHALL hold last captured values until next capture.
REQ-022 DBG_RDATA SHALL reflect r[DBG_RADDR] including a write in the same cycle only after the edge.

Reset
REQ-023 RST_L low SHALL immediately force IDLE, r0..r7=0, ALU_A/ALU_B=0, ALU_OP=0, WB_DATA=0, FLAGS=0, WB_VALID=0, counter=0.
REQ-024 Reset asserted in EXEC or DONE SHALL abort the operation with no register write-back after release.
REQ-025 First accept SHALL be possible on the first edge after RST_L deasserts.

Structure
REQ-026 Shared package alu_pkg SHALL hold state encoding, opcode width, register-index width, FLAGS bit indices.
REQ-027 Register file SHALL be sub-module regfile (8x8, one write port, three combinational read ports: RA, RB, DBG).
REQ-028 FSM, counter and capture registers SHALL reside in alu_issue_unit; alu instantiated by the top level, not inside.

Verification
REQ-029 Bench ALU model Y=A+B: LD r1=0x0F, r2=0x01; issue OP=0,RD=3,RA=1,RB=2 -> WB_VALID one cycle at accept+2, WB_DATA=0x10, DBG r3=0x10.
REQ-030 Chained: after REQ-029 issue RD=3,RA=3,RB=3 -> WB_DATA=0x20; ALU flags forced C=1,Z=0 -> FLAGS=4'b1000.
REQ-031 LD_EN and IN_VALID together in IDLE -> IN_READY=0, load completes, instruction accepted next cycle.
REQ-032 EXEC_CYCLES=3: accept -> WB_VALID at accept+4; IN_VALID held high during EXEC not accepted; LD_EN in EXEC leaves register unchanged.
REQ-033 RST_L low mid-EXEC with RD=5 preloaded 0xAA -> after release r5=0x00, WB_VALID never pulses, FLAGS=0.
REQ-034 Back-to-back IN_VALID held high, EXEC_CYCLES=1 -> accepts exactly every 3 cycles, one WB_VALID pulse per accept.
